// File: rtl/toy_decode_issue_ctrl.sv
// ----------------------------------------------------------------------------
// toy_decode_issue_ctrl
//
// Sits between the fetch buffer and a bank of DEC_NUM parallel decoder lanes.
// Each cycle it can take a contiguous, oldest-first prefix of the fetch
// window into a registered issue group. The group is presented to the
// decoder lanes with independent per-lane valid/ready handshakes. A CSR
// interrupt-injection request is served by a small drain/inject state
// machine. It waits for the current group to drain, then issues a single
// marker instruction on lane 0. A pipeline flush drops everything in flight.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             pipeline flush (highest priority)
//   fe_vld / fe_rdy   fetch entry valid / consumed, entry 0 is oldest
//   fe_inst/pc/idx    fetch payload, FE_CH entries packed low-to-high
//   dec_vld / dec_rdy per-lane decoder handshake
//   dec_inst/pc/idx   per-lane payload, DEC_NUM lanes packed low-to-high
//   dec_intr          lane carries the interrupt marker
//   csr_intr_vld/pc   interrupt-injection request (held until accepted)
//   csr_intr_rdy      injection accepted this cycle
//
// Optional feature macro: TOY_DEC_ISSUE_PERF_EN
//   Adds perf_issued (non-interrupt lane fires) and perf_stall (IDLE with
//   fetch waiting but the group not free) counters, CNT_W bits, wrapping.
// ----------------------------------------------------------------------------
module toy_decode_issue_ctrl #(
    parameter int FE_CH   = 8,
    parameter int DEC_NUM = 4,
    parameter int INST_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [FE_CH-1:0]          fe_vld,
    output logic [FE_CH-1:0]          fe_rdy,
    input  logic [FE_CH*INST_W-1:0]   fe_inst,
    input  logic [FE_CH*ADDR_W-1:0]   fe_pc,
    input  logic [FE_CH*IDX_W-1:0]    fe_idx,
    output logic [DEC_NUM-1:0]        dec_vld,
    input  logic [DEC_NUM-1:0]        dec_rdy,
    output logic [DEC_NUM*INST_W-1:0] dec_inst,
    output logic [DEC_NUM*ADDR_W-1:0] dec_pc,
    output logic [DEC_NUM*IDX_W-1:0]  dec_idx,
    output logic [DEC_NUM-1:0]        dec_intr,
    input  logic                      csr_intr_vld,
    input  logic [ADDR_W-1:0]         csr_intr_pc,
    output logic                      csr_intr_rdy
`ifdef TOY_DEC_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]          perf_issued,
    output logic [CNT_W-1:0]          perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WAIT_ACK
    } state_e;

    state_e state_q;

    logic [DEC_NUM-1:0]        vld_q,  vld_d;
    logic [DEC_NUM-1:0]        intr_q, intr_d;
    logic [DEC_NUM*INST_W-1:0] inst_q, inst_d;
    logic [DEC_NUM*ADDR_W-1:0] pc_q,   pc_d;
    logic [DEC_NUM*IDX_W-1:0]  idx_q,  idx_d;

    logic [DEC_NUM-1:0] fire;
    logic [DEC_NUM-1:0] take;
    logic               free;
    logic               load_en;
    logic               inj_en;

    // Upper fetch entries are never consumed; fold them here so they are
    // visibly intentionally unused.
    logic unused_fe;
    assign unused_fe = ^{fe_vld, fe_inst, fe_pc, fe_idx};

    // A lane is free when it is empty or handing off this very cycle, so a
    // new group can be loaded back-to-back with full throughput.
    assign fire = vld_q & dec_rdy;
    assign free = &(~vld_q | dec_rdy);

    // Running AND over fe_vld: a hole in the fetch window stops the take,
    // which keeps the loaded lanes a contiguous in-order prefix.
    always_comb begin
        logic run;
        run  = 1'b1;
        take = '0;
        for (int k = 0; k < DEC_NUM; k++) begin
            run     = run & fe_vld[k];
            take[k] = run;
        end
    end

    // Interrupt requests block fetch even in IDLE so the drain starts at once.
    // Both handshakes are masked during reset so nothing is consumed then.
    assign load_en = !rst && (state_q == ST_IDLE) && free && !flush && !csr_intr_vld;
    assign inj_en  = !rst && (state_q == ST_DRAIN) && free && !flush && csr_intr_vld;

    always_comb begin
        fe_rdy = '0;
        for (int k = 0; k < DEC_NUM; k++) begin
            fe_rdy[k] = load_en & take[k];
        end
    end

    assign csr_intr_rdy = inj_en;

    // Drain/inject sequencer: flush always returns to IDLE; DRAIN waits for
    // the group to empty (or the request to be withdrawn); WAIT_ACK holds
    // fetch off until the marker on lane 0 is taken by the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csr_intr_vld) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!csr_intr_vld) state_q <= ST_IDLE;
                    else if (inj_en)   state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (fire[0]) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Lane next-state: flush drops the group, a load or injection replaces
    // it, otherwise fired lanes retire and unfired lanes hold their payload.
    // Lanes not taken by a load keep their stale payload but are invalid.
    always_comb begin
        vld_d  = vld_q;
        intr_d = intr_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        idx_d  = idx_q;
        if (flush) begin
            vld_d  = '0;
            intr_d = '0;
        end else if (load_en) begin
            vld_d  = take;
            intr_d = '0;
            for (int k = 0; k < DEC_NUM; k++) begin
                if (take[k]) begin
                    inst_d[k*INST_W +: INST_W] = fe_inst[k*INST_W +: INST_W];
                    pc_d[k*ADDR_W +: ADDR_W]   = fe_pc[k*ADDR_W +: ADDR_W];
                    idx_d[k*IDX_W +: IDX_W]    = fe_idx[k*IDX_W +: IDX_W];
                end
            end
        end else if (inj_en) begin
            vld_d                 = '0;
            vld_d[0]              = 1'b1;
            intr_d                = '0;
            intr_d[0]             = 1'b1;
            inst_d[0 +: INST_W]   = '0;
            pc_d[0 +: ADDR_W]     = csr_intr_pc;
            idx_d[0 +: IDX_W]     = '0;
        end else begin
            vld_d  = vld_q & ~fire;
            intr_d = intr_q & ~fire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            intr_q <= '0;
            inst_q <= '0;
            pc_q   <= '0;
            idx_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            intr_q <= intr_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
            idx_q  <= idx_d;
        end
    end

    assign dec_vld  = vld_q;
    assign dec_intr = intr_q;
    assign dec_inst = inst_q;
    assign dec_pc   = pc_q;
    assign dec_idx  = idx_q;

`ifdef TOY_DEC_ISSUE_PERF_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    // Only real instructions count as issued; the interrupt marker does not.
    always_comb begin
        issued_d = issued_q;
        for (int k = 0; k < DEC_NUM; k++) begin
            issued_d = issued_d + CNT_W'(fire[k] & ~intr_q[k]);
        end
        stall_d = stall_q + CNT_W'((state_q == ST_IDLE) && fe_vld[0] && !free);
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stall  = stall_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
